bcd_gray_arbiter: RTL and testbench

Round-robin scheduler that shares a single BCD-to-Gray conversion datapath among N_REQ requesters. Each requester presents one BCD digit with a request. The block grants one requester at a time, converts the digit, and presents the registered Gray result with the requester's ID to one downstream consumer through a valid/ready handshake. It sits between the lab's digit sources and the shared converter, and it owns all sequencing of that converter.

---
 rtl/bcd_gray_arbiter.sv | 121 ++++++++++++
 tb/tb_bcd_gray_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_gray_arbiter.sv
// Round-robin front end for a shared BCD-to-Gray converter.
// One requester is served at a time; results leave on a valid/ready port.
module bcd_gray_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   bcd_in,
  input  logic                 out_ready,
  output logic [N_REQ-1:0]     ack,
  output logic [3:0]           gray_out,
  output logic [IDW-1:0]       gray_id,
  output logic                 gray_valid,
  output logic                 bcd_err,
  output logic [7:0]           conv_count
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    PRESENT
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cap_id;
  logic [3:0]     cap_bcd;
  logic [IDW-1:0] grant;
  logic [IDW-1:0] idx;
  logic           found;
  logic [3:0]     pick;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    logic [3:0] g;
    if (b > 4'd9) begin
      g = 4'b0000;
    end else begin
      g = {b[3], b[3] | b[2], b[2] ^ b[1], b[1] ^ b[0]};
    end
    return g;
  endfunction

  // Search starts just after the last grant so every requester gets a turn.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDW'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign pick = bcd_in[{grant, 2'b00} +: 4];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = CONV;
      CONV:    state_nx = PRESENT;
      PRESENT: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state == CONV) ack[cap_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= IDW'(N_REQ - 1);
      cap_id     <= '0;
      cap_bcd    <= '0;
      gray_out   <= '0;
      gray_id    <= '0;
      gray_valid <= 1'b0;
      bcd_err    <= 1'b0;
      conv_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            ptr     <= grant;
            cap_id  <= grant;
            cap_bcd <= pick;
          end
        end
        CONV: begin
          gray_out   <= to_gray(cap_bcd);
          bcd_err    <= (cap_bcd > 4'd9);
          gray_id    <= cap_id;
          gray_valid <= 1'b1;
        end
        PRESENT: begin
          if (out_ready) begin
            gray_valid <= 1'b0;
            conv_count <= conv_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_gray_arbiter.sv
// Scoreboard bench for bcd_gray_arbiter.
// Expected results are queued at grant time and popped on gray_valid.
module tb_bcd_gray_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] bcd_in;
  logic        out_ready;
  logic [3:0]  ack;
  logic [3:0]  gray_out;
  logic [1:0]  gray_id;
  logic        gray_valid;
  logic        bcd_err;
  logic [7:0]  conv_count;

  bcd_gray_arbiter #(.N_REQ(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .bcd_in     (bcd_in),
    .out_ready  (out_ready),
    .ack        (ack),
    .gray_out   (gray_out),
    .gray_id    (gray_id),
    .gray_valid (gray_valid),
    .bcd_err    (bcd_err),
    .conv_count (conv_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] id;
    logic [3:0] g;
    logic       e;
  } exp_t;

  exp_t       q[$];
  exp_t       ex;
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [3:0] gtab [10] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6,
                            4'h7, 4'h5, 4'h4, 4'hC, 4'hD};

  always @(posedge clk) cyc++;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack != 4'b0000) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gray_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (q.size() != 0);
    e  = '0;
    if (ok) e = q.pop_front();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    bcd_in = '0;
    out_ready = 1'b1;
    repeat (2) tick();
    total++;
    if ({ack, gray_out, gray_id, gray_valid, bcd_err, conv_count} !== '0) begin
      bad++;
      $display("FAIL reset_outs got ack=%b g=%b id=%0d v=%b e=%b cnt=%0d req=0",
               ack, gray_out, gray_id, gray_valid, bcd_err, conv_count);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (ack !== 4'b0000 || gray_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got ack=%b v=%b req=0000/0", ack, gray_valid);
    end
    exp_cnt = 8'd0;
  endtask

  task automatic test_round_robin();
    bit ok;
    bit pk;
    int last;
    bcd_in = {4'd9, 4'd1, 4'd7, 4'd3};
    req = 4'b1111;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      ex.id = 2'(i % 4);
      ex.g  = gtab[bcd_in[4*(i%4) +: 4]];
      ex.e  = 1'b0;
      q.push_back(ex);
      wait_ack(ok);
      total++;
      if (!ok || ack !== (4'b0001 << (i % 4))) begin
        bad++;
        $display("FAIL rr_ack%0d got=%b req=%b", i, ack, 4'b0001 << (i % 4));
      end
      if (i > 0) begin
        total++;
        if (cyc - last != 3) begin
          bad++;
          $display("FAIL rr_period%0d got=%0d req=3", i, cyc - last);
        end
      end
      last = cyc;
      if (i == 4) req = 4'b0000;
      wait_valid(ok);
      pop_exp(ex, pk);
      total++;
      if (!ok || !pk || gray_id !== ex.id || gray_out !== ex.g || bcd_err !== ex.e) begin
        bad++;
        $display("FAIL rr_data%0d got id=%0d g=%b e=%b req id=%0d g=%b e=%b",
                 i, gray_id, gray_out, bcd_err, ex.id, ex.g, ex.e);
      end
      exp_cnt++;
    end
    tick();
    total++;
    if (conv_count !== exp_cnt || gray_valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_count got=%0d v=%b req=%0d v=0", conv_count, gray_valid, exp_cnt);
    end
  endtask

  task automatic test_single();
    bit ok;
    bit pk;
    bcd_in = '0;
    bcd_in[3:0] = 4'd5;
    req = 4'b0001;
    q.push_back('{id: 2'd0, g: 4'b0111, e: 1'b0});
    wait_ack(ok);
    total++;
    if (!ok || ack !== 4'b0001) begin
      bad++;
      $display("FAIL single_ack got=%b req=0001", ack);
    end
    req = 4'b0000;
    tick();
    pop_exp(ex, pk);
    total++;
    if (!pk || gray_valid !== 1'b1 || ack !== 4'b0000 || gray_id !== ex.id
        || gray_out !== ex.g || bcd_err !== ex.e) begin
      bad++;
      $display("FAIL single_data got v=%b ack=%b id=%0d g=%b e=%b req v=1 ack=0 id=%0d g=%b e=%b",
               gray_valid, ack, gray_id, gray_out, bcd_err, ex.id, ex.g, ex.e);
    end
    exp_cnt++;
    tick();
    total++;
    if (conv_count !== exp_cnt || gray_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_count got=%0d v=%b req=%0d v=0", conv_count, gray_valid, exp_cnt);
    end
  endtask

  task automatic test_sweep();
    bit ok;
    bit pk;
    for (int d = 0; d < 10; d++) begin
      bcd_in = '0;
      bcd_in[11:8] = 4'(d);
      req = 4'b0100;
      q.push_back('{id: 2'd2, g: gtab[d], e: 1'b0});
      wait_ack(ok);
      total++;
      if (!ok || ack !== 4'b0100) begin
        bad++;
        $display("FAIL sweep_ack%0d got=%b req=0100", d, ack);
      end
      req = 4'b0000;
      wait_valid(ok);
      pop_exp(ex, pk);
      total++;
      if (!ok || !pk || gray_id !== ex.id || gray_out !== ex.g || bcd_err !== ex.e) begin
        bad++;
        $display("FAIL sweep_data%0d got id=%0d g=%b e=%b req id=%0d g=%b e=%b",
                 d, gray_id, gray_out, bcd_err, ex.id, ex.g, ex.e);
      end
      exp_cnt++;
      tick();
    end
    total++;
    if (conv_count !== exp_cnt) begin
      bad++;
      $display("FAIL sweep_count got=%0d req=%0d", conv_count, exp_cnt);
    end
  endtask

  task automatic test_stall();
    bit ok;
    bit pk;
    out_ready = 1'b0;
    bcd_in = '0;
    bcd_in[15:12] = 4'd8;
    bcd_in[7:4] = 4'd4;
    req = 4'b1010;
    q.push_back('{id: 2'd3, g: 4'b1100, e: 1'b0});
    q.push_back('{id: 2'd1, g: 4'b0110, e: 1'b0});
    wait_ack(ok);
    total++;
    if (!ok || ack !== 4'b1000) begin
      bad++;
      $display("FAIL stall_ack3 got=%b req=1000", ack);
    end
    req = 4'b0010;
    wait_valid(ok);
    pop_exp(ex, pk);
    for (int c = 0; c < 6; c++) begin
      total++;
      if (!ok || !pk || gray_valid !== 1'b1 || ack !== 4'b0000 || gray_id !== ex.id
          || gray_out !== ex.g || bcd_err !== ex.e || conv_count !== exp_cnt) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%b ack=%b id=%0d g=%b cnt=%0d req v=1 ack=0 id=%0d g=%b cnt=%0d",
                 c, gray_valid, ack, gray_id, gray_out, conv_count, ex.id, ex.g, exp_cnt);
      end
      tick();
    end
    out_ready = 1'b1;
    exp_cnt++;
    tick();
    total++;
    if (gray_valid !== 1'b0 || conv_count !== exp_cnt) begin
      bad++;
      $display("FAIL stall_release got v=%b cnt=%0d req v=0 cnt=%0d", gray_valid, conv_count, exp_cnt);
    end
    wait_ack(ok);
    total++;
    if (!ok || ack !== 4'b0010) begin
      bad++;
      $display("FAIL stall_ack1 got=%b req=0010", ack);
    end
    req = 4'b0000;
    wait_valid(ok);
    pop_exp(ex, pk);
    total++;
    if (!ok || !pk || gray_id !== ex.id || gray_out !== ex.g || bcd_err !== ex.e) begin
      bad++;
      $display("FAIL stall_data got id=%0d g=%b e=%b req id=%0d g=%b e=%b",
               gray_id, gray_out, bcd_err, ex.id, ex.g, ex.e);
    end
    exp_cnt++;
    tick();
  endtask

  task automatic test_bad_digit();
    bit ok;
    bit pk;
    bcd_in = '0;
    bcd_in[7:4] = 4'd12;
    req = 4'b0010;
    q.push_back('{id: 2'd1, g: 4'b0000, e: 1'b1});
    wait_ack(ok);
    req = 4'b0000;
    wait_valid(ok);
    pop_exp(ex, pk);
    total++;
    if (!ok || !pk || gray_id !== ex.id || gray_out !== ex.g || bcd_err !== ex.e) begin
      bad++;
      $display("FAIL err_data got id=%0d g=%b e=%b req id=%0d g=%b e=%b",
               gray_id, gray_out, bcd_err, ex.id, ex.g, ex.e);
    end
    exp_cnt++;
    tick();
    total++;
    if (conv_count !== exp_cnt || gray_valid !== 1'b0) begin
      bad++;
      $display("FAIL err_count got=%0d v=%b req=%0d v=0", conv_count, gray_valid, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit pk;
    bcd_in = {4'd5, 4'd6, 4'd7, 4'd2};
    req = 4'b1000;
    q.push_back('{id: 2'd3, g: 4'b0111, e: 1'b0});
    wait_ack(ok);
    total++;
    if (!ok || ack !== 4'b1000) begin
      bad++;
      $display("FAIL mid_ack3 got=%b req=1000", ack);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({ack, gray_out, gray_id, gray_valid, bcd_err, conv_count} !== '0) begin
      bad++;
      $display("FAIL mid_reset got ack=%b g=%b id=%0d v=%b e=%b cnt=%0d req=0",
               ack, gray_out, gray_id, gray_valid, bcd_err, conv_count);
    end
    q.delete();
    exp_cnt = 8'd0;
    req = 4'b1111;
    tick();
    rst_n = 1'b1;
    q.push_back('{id: 2'd0, g: 4'b0011, e: 1'b0});
    wait_ack(ok);
    total++;
    if (!ok || ack !== 4'b0001) begin
      bad++;
      $display("FAIL mid_first got=%b req=0001", ack);
    end
    req = 4'b0000;
    wait_valid(ok);
    pop_exp(ex, pk);
    total++;
    if (!ok || !pk || gray_id !== ex.id || gray_out !== ex.g || bcd_err !== ex.e) begin
      bad++;
      $display("FAIL mid_data got id=%0d g=%b e=%b req id=%0d g=%b e=%b",
               gray_id, gray_out, bcd_err, ex.id, ex.g, ex.e);
    end
    exp_cnt++;
    tick();
    total++;
    if (conv_count !== exp_cnt) begin
      bad++;
      $display("FAIL mid_count got=%0d req=%0d", conv_count, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_sweep();
    test_stall();
    test_bad_digit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
